count_display: RTL and testbench
================================

Name: count_display

Overview:
- Downstream consumer of the 5-bit up/down counter value (0..31).
- Converts the count to two decimal digits and drives a time-multiplexed, two-digit common-anode 7-segment display.
- Has a per-digit scan prescaler, inter-digit ghost blanking, and a frame-coherent snapshot of the count.
- Sits between the counter and the board's segment/digit pins.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is selected; legal range 2..2^20.
- BLANK_CYC, 2: cycles at the start of each digit period with all digits off; legal range 0..SCAN_DIV-1.
- SEG_ACTIVE_LOW, 1: 1 means seg outputs are active-low; 0 means active-high.
- DIG_ACTIVE_LOW, 1: 1 means dig outputs are active-low; 0 means active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- count  input  5  binary counter value, 0..31, sampled synchronously.
- seg  output  7  segments, seg[0]=a .. seg[6]=g; registered.
- dig  output  2  digit enables, dig[0]=ones, dig[1]=tens; registered.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high: prescaler p=0, phase=ONES, snap=0.
  - seg = all segments off (7'h7F when active-low).
  - dig = both digits off (2'b11 when active-low).
- Prescaler:
  - p counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where p==SCAN_DIV-1.
- Phase FSM, two states, ONES and TENS:
  - On tick, ONES goes to TENS and TENS goes to ONES.
  - No other transitions exist.
- Snapshot:
  - On a tick where phase==TENS (i.e. entering ONES), snap <= count.
  - Both digits of one frame therefore always show the same value; count changes mid-frame are deferred to the next frame.
  - snap holds its value at all other times.
- Conversion, combinational from snap:
  - tens = snap/10, range 0..3 (2 bits).
  - ones = snap - 10*tens, range 0..9 (4 bits).
  - No divider primitive: use compare/subtract against 10, 20 and 30.
- Segment code, active-high form (g..a):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Invert all bits when SEG_ACTIVE_LOW=1.
- Output register, loaded every cycle from the current p, phase and snap (latency 1 clk):
  - If p < BLANK_CYC: dig = both off, seg = all off.
  - Else if phase==ONES: dig = ones digit on only; seg = code(ones).
  - Else (TENS): dig = tens digit on only; seg = code(tens).
- Invariant: at most one digit is ever enabled at a time.
- Each digit is held enabled for exactly SCAN_DIV-BLANK_CYC cycles per SCAN_DIV period; one frame = 2*SCAN_DIV cycles.
- After reset release, the first frame displays 00 (snap=0) until the first snapshot at the end of the first TENS period.
- count values are always 0..31 (5 bits), so no out-of-range handling is needed.
- Reset asserted mid-operation: outputs blank in the same instant (asynchronous), and the scan restarts from p=0, phase=ONES.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: when phase==TENS and tens==0, seg = all off. The tens dig enable still follows the normal scan timing, so brightness stays uniform.
- Not defined: a tens digit of 0 displays "0" (code 0x3F, i.e. 7'h40 when active-low).

Test Plan:
Bench settings: SCAN_DIV=4, BLANK_CYC=1, both ACTIVE_LOW=1.
- Reset: rst=1 for 3 clk with count=9 -> seg=7'h7F, dig=2'b11 throughout. First ONES window after release shows seg=7'h40 ("0"), dig=2'b10.
- Scan timing: count held at 23 -> per 4-cycle digit period, 1 cycle dig=2'b11 then 3 cycles dig=2'b10 (ONES) or 2'b01 (TENS). Never dig=2'b00.
- Digit values: count=23 after a snapshot -> ONES window seg=7'h30 ("3"); TENS window seg=7'h24 ("2").
- Coherence: count 23 changed to 17 during a TENS window -> that window still shows seg=7'h24. Next frame shows ONES 7'h78 ("7"), then TENS 7'h79 ("1").
- Boundaries: count=31 -> ones 7'h79, tens 7'h30. count=0 -> ones 7'h40; tens 7'h40 without the macro, 7'h7F with LEAD_ZERO_BLANK_EN.
- Reset mid-operation: assert rst during a TENS window with dig=2'b01 -> dig=2'b11 and seg=7'h7F before the next clk edge. After release the scan restarts at ONES with snap=0.

Source files
------------

// File: rtl/count_display_if.sv
// Bundle of the counter value and the display pins shared by the counter side and count_display.
`timescale 1ns/1ps
interface count_display_if;
  logic [4:0] count;
  logic [6:0] seg;
  logic [1:0] dig;

  modport master (output count, input seg, input dig);
  modport slave  (input count, output seg, output dig);
endinterface

// File: rtl/count_display.sv
// Two-digit multiplexed 7-segment driver for a 0..31 count, with frame-coherent snapshot.
// Optional macro LEAD_ZERO_BLANK_EN blanks the segments of a tens digit equal to 0.
`timescale 1ns/1ps
module count_display #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  count_display_if.slave  bus
);

  localparam int             P_W     = $clog2(SCAN_DIV);
  localparam logic [P_W-1:0] P_LAST  = P_W'(SCAN_DIV - 1);
  localparam logic [P_W-1:0] P_BLANK = P_W'(BLANK_CYC);

  localparam logic [0:0] PH_ONES = 1'b0;
  localparam logic [0:0] PH_TENS = 1'b1;

  localparam logic [6:0] SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [1:0] DIG_ONES = (DIG_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;
  localparam logic [1:0] DIG_TENS = (DIG_ACTIVE_LOW != 0) ? 2'b01 : 2'b10;

  logic [P_W-1:0] p_r;
  logic [0:0]     phase_r;
  logic [0:0]     phase_nxt_s;
  logic [4:0]     snap_r;
  logic           tick_s;
  logic [1:0]     tens_s;
  logic [3:0]     ones_s;
  logic [6:0]     seg_nxt_s;
  logic [1:0]     dig_nxt_s;
  logic [6:0]     seg_r;
  logic [1:0]     dig_r;

  // Active-high segment pattern (g..a) for a decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] seg_drive(input logic [6:0] code);
    return (SEG_ACTIVE_LOW != 0) ? ~code : code;
  endfunction

  assign tick_s = (p_r == P_LAST);

  // Scan prescaler: one digit period is SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r <= '0;
    end else if (tick_s) begin
      p_r <= '0;
    end else begin
      p_r <= p_r + P_W'(1);
    end
  end

  // Phase next-state: toggles between ONES and TENS on each tick.
  always_comb begin
    phase_nxt_s = PH_ONES;
    case (phase_r)
      PH_ONES: phase_nxt_s = tick_s ? PH_TENS : PH_ONES;
      PH_TENS: phase_nxt_s = tick_s ? PH_ONES : PH_TENS;
      default: phase_nxt_s = PH_ONES;
    endcase
  end

  // Phase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PH_ONES;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  // Snapshot only at the frame boundary so both digits of a frame agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r <= 5'd0;
    end else if (tick_s && (phase_r == PH_TENS)) begin
      snap_r <= bus.count;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Binary to two decimal digits by compare/subtract against 30, 20, 10.
  always_comb begin
    tens_s = 2'd0;
    ones_s = 4'd0;
    if (snap_r >= 5'd30) begin
      tens_s = 2'd3;
      ones_s = 4'(snap_r - 5'd30);
    end else if (snap_r >= 5'd20) begin
      tens_s = 2'd2;
      ones_s = 4'(snap_r - 5'd20);
    end else if (snap_r >= 5'd10) begin
      tens_s = 2'd1;
      ones_s = 4'(snap_r - 5'd10);
    end else begin
      tens_s = 2'd0;
      ones_s = snap_r[3:0];
    end
  end

  // Output selection: ghost blanking at the start of each digit period.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    dig_nxt_s = DIG_OFF;
    if (p_r < P_BLANK) begin
      seg_nxt_s = SEG_OFF;
      dig_nxt_s = DIG_OFF;
    end else if (phase_r == PH_ONES) begin
      dig_nxt_s = DIG_ONES;
      seg_nxt_s = seg_drive(seg_code(ones_s));
    end else begin
      dig_nxt_s = DIG_TENS;
`ifdef LEAD_ZERO_BLANK_EN
      if (tens_s == 2'd0) begin
        seg_nxt_s = SEG_OFF;
      end else begin
        seg_nxt_s = seg_drive(seg_code({2'b00, tens_s}));
      end
`else
      seg_nxt_s = seg_drive(seg_code({2'b00, tens_s}));
`endif
    end
  end

  // Registered pin drivers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_OFF;
      dig_r <= DIG_OFF;
    end else begin
      seg_r <= seg_nxt_s;
      dig_r <= dig_nxt_s;
    end
  end

  assign bus.seg = seg_r;
  assign bus.dig = dig_r;

endmodule

// File: tb/tb_count_display.sv
// Randomized self-checking bench for count_display (SCAN_DIV=4, BLANK_CYC=1, active-low pins).
`timescale 1ns/1ps
module tb_count_display;

  localparam int S = 4;
  localparam int B = 1;

  logic clk;
  logic rst;
  count_display_if bus ();

  count_display #(
    .SCAN_DIV(S), .BLANK_CYC(B), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [4:0] hist [0:2047];
  logic [6:0] hi_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what the pins show for scan cycle k (k counted from reset release).
  function automatic logic [8:0] expect_out(input int k);
    int f, snapv, p, ph, d;
    f     = k / (2 * S);
    snapv = (f == 0) ? 0 : int'(hist[f * 2 * S - 1]);
    p     = k % S;
    ph    = (k / S) % 2;
    if (p < B) return {7'h7F, 2'b11};
    d = (ph == 1) ? snapv / 10 : snapv % 10;
`ifdef LEAD_ZERO_BLANK_EN
    if (ph == 1 && d == 0) return {7'h7F, 2'b01};
`endif
    return {~hi_tab[d], (ph == 1) ? 2'b01 : 2'b10};
  endfunction

  // One clock: drive count, advance, land on the next falling edge.
  task automatic cyc(input logic [4:0] c);
    bus.count = c;
    hist[n] = c;
    @(posedge clk);
    n = n + 1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [8:0] want;
    rst = 1'b1;
    bus.count = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.seg, bus.dig} !== {7'h7F, 2'b11}) begin
        bad++;
        $display("FAIL reset_hold got seg=%h dig=%b want seg=7f dig=11", bus.seg, bus.dig);
      end
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(5'd9);
      want = (i == 0) ? {7'h7F, 2'b11} : {7'h40, 2'b10};
      total++;
      if ({bus.seg, bus.dig} !== want) begin
        bad++;
        $display("FAIL reset_first_ones k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                 n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
      end
    end
  endtask

  task automatic test_scan_timing;
    logic [8:0] want;
    int m;
    for (int i = 0; i < 24; i++) begin
      cyc(5'd23);
      want = expect_out(n - 1);
      total++;
      if ({bus.seg, bus.dig} !== want) begin
        bad++;
        $display("FAIL scan_model k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                 n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
      end
      total++;
      if (bus.dig === 2'b00) begin
        bad++;
        $display("FAIL scan_two_digits k=%0d got dig=%b want at most one enabled", n - 1, bus.dig);
      end
      if (i >= 16) begin
        m = (n - 1) % 8;
        if (m == 0 || m == 4) want = {7'h7F, 2'b11};
        else if (m < 4)       want = {7'h30, 2'b10};
        else                  want = {7'h24, 2'b01};
        total++;
        if ({bus.seg, bus.dig} !== want) begin
          bad++;
          $display("FAIL digits_23 k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                   n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
        end
      end
    end
  endtask

  task automatic test_coherence;
    logic [8:0] want;
    int n0, m;
    for (int i = 0; i < 8 && (n % 8) != 5; i++) cyc(5'd23);
    n0 = n;
    for (int i = 0; i < 11; i++) begin
      cyc(5'd17);
      m = (n - 1) % 8;
      if (m == 0 || m == 4)    want = {7'h7F, 2'b11};
      else if (n - 1 - n0 < 3) want = {7'h24, 2'b01};
      else if (m < 4)          want = {7'h78, 2'b10};
      else                     want = {7'h79, 2'b01};
      total++;
      if ({bus.seg, bus.dig} !== want) begin
        bad++;
        $display("FAIL coherence k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                 n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [8:0] want;
    logic [6:0] tens0;
    logic [4:0] val;
    int m;
`ifdef LEAD_ZERO_BLANK_EN
    tens0 = 7'h7F;
`else
    tens0 = 7'h40;
`endif
    for (int v = 0; v < 2; v++) begin
      val = (v == 0) ? 5'd31 : 5'd0;
      for (int i = 0; i < 24; i++) begin
        cyc(val);
        want = expect_out(n - 1);
        total++;
        if ({bus.seg, bus.dig} !== want) begin
          bad++;
          $display("FAIL bound_model val=%0d k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                   val, n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
        end
        if (i >= 16) begin
          m = (n - 1) % 8;
          if (m == 0 || m == 4) want = {7'h7F, 2'b11};
          else if (m < 4)       want = {(v == 0) ? 7'h79 : 7'h40, 2'b10};
          else                  want = {(v == 0) ? 7'h30 : tens0, 2'b01};
          total++;
          if ({bus.seg, bus.dig} !== want) begin
            bad++;
            $display("FAIL bound_digits val=%0d k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                     val, n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [8:0] want;
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) c = 5'($urandom_range(0, 31));
      cyc(c);
      want = expect_out(n - 1);
      total++;
      if ({bus.seg, bus.dig} !== want) begin
        bad++;
        $display("FAIL random k=%0d count=%0d got seg=%h dig=%b want seg=%h dig=%b",
                 n - 1, c, bus.seg, bus.dig, want[8:2], want[1:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] want;
    logic [6:0] tens0;
    int guard;
    int m;
`ifdef LEAD_ZERO_BLANK_EN
    tens0 = 7'h7F;
`else
    tens0 = 7'h40;
`endif
    guard = 0;
    while (bus.dig !== 2'b01 && guard < 20) begin
      cyc(5'd27);
      guard++;
    end
    total++;
    if (bus.dig !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_wait got dig=%b want 01 within 20 cycles", bus.dig);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.seg, bus.dig} !== {7'h7F, 2'b11}) begin
      bad++;
      $display("FAIL reset_mid_async got seg=%h dig=%b want seg=7f dig=11", bus.seg, bus.dig);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(5'd5);
      m = (n - 1) % 8;
      if (m == 0 || m == 4) want = {7'h7F, 2'b11};
      else if (m < 4)       want = {7'h40, 2'b10};
      else                  want = {tens0, 2'b01};
      total++;
      if ({bus.seg, bus.dig} !== want) begin
        bad++;
        $display("FAIL reset_mid_restart k=%0d got seg=%h dig=%b want seg=%h dig=%b",
                 n - 1, bus.seg, bus.dig, want[8:2], want[1:0]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.count = 5'd0;
    test_reset();
    test_scan_timing();
    test_coherence();
    test_boundaries();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
